// File: rtl/codec_serial_intf.sv
// Purpose : I2S serial port to a CS4272 CODEC. Derives MCLK/SCLK/LRCLK from clk,
//           drives the CODEC reset, deserializes SDout and serializes SDin.
// Latency : last right-channel bit sampled -> vld one clk later; samples captured
//           at vld are transmitted in the following frame.
// Backpr. : none; one vld per 2^CNT_W clk, consumer must take the strobe.
// Ports   : clk/rst (sync, active high); MCLK/SCLK/LRCLK/RSTn/SDin to the CODEC,
//           SDout from it; lft_out/rht_out in, lft_in/rht_in/vld out.
// Option  : define CODEC_LOOPBACK_EN to feed received samples back to the DAC.
module codec_serial_intf #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              RSTn,
    input  logic              SDout,
    output logic              SDin,
    input  logic [DATA_W-1:0] lft_out,
    input  logic [DATA_W-1:0] rht_out,
    output logic [DATA_W-1:0] lft_in,
    output logic [DATA_W-1:0] rht_in,
    output logic              vld
);
    // 16 clk per bit slot, so a half-frame holds 2^(CNT_W-5) slots.
    localparam int SLOT_W = CNT_W - 5;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rstn_q, rstn_d;
    logic [1:0]        frm_q, frm_d;
    logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d, hold_l_q, hold_l_d;
    logic [DATA_W-1:0] lft_in_q, lft_in_d, rht_in_q, rht_in_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] txb_l_q, txb_l_d, txb_r_q, txb_r_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              sdin_q, sdin_d;

    logic [SLOT_W-1:0] slot;
    logic              lr, sclk_rise, sclk_fall, wrap, rload, rx_slot, tx_slot, last_slot;
    logic [DATA_W-1:0] tx_src_l, tx_src_r;

    assign slot      = cnt_q[CNT_W-2:4];
    assign lr        = cnt_q[CNT_W-1];
    assign sclk_rise = (cnt_q[3:0] == 4'd7);
    assign sclk_fall = (cnt_q[3:0] == 4'd15);
    assign wrap      = (cnt_q == {CNT_W{1'b1}});
    assign rload     = (cnt_q == {1'b0, {(CNT_W-1){1'b1}}});
    assign rx_slot   = (slot >= SLOT_W'(1)) && (slot <= SLOT_W'(DATA_W));
    assign last_slot = (slot == SLOT_W'(DATA_W));
    // Bit for slot k is driven on the fall of slot k-1, i.e. slots 0..DATA_W-1.
    assign tx_slot   = (slot < SLOT_W'(DATA_W));

`ifdef CODEC_LOOPBACK_EN
    // In the vld cycle lft_in/rht_in already hold the newly received pair.
    assign tx_src_l = lft_in_q;
    assign tx_src_r = rht_in_q;
    logic unused_tx_ports;
    assign unused_tx_ports = ^{lft_out, rht_out};
`else
    assign tx_src_l = lft_out;
    assign tx_src_r = rht_out;
`endif

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        rstn_d   = rstn_q | wrap;
        frm_d    = frm_q;
        rx_l_d   = rx_l_q;
        rx_r_d   = rx_r_q;
        hold_l_d = hold_l_q;
        lft_in_d = lft_in_q;
        rht_in_d = rht_in_q;
        vld_d    = 1'b0;
        txb_l_d  = txb_l_q;
        txb_r_d  = txb_r_q;
        tx_sh_d  = tx_sh_q;
        sdin_d   = sdin_q;

        // Frame counter only runs once the CODEC is out of reset; saturates at 3.
        if (wrap && rstn_q && frm_q != 2'd3)
            frm_d = frm_q + 2'd1;

        if (sclk_rise && rx_slot) begin
            if (!lr) rx_l_d = {rx_l_q[DATA_W-2:0], SDout};
            else     rx_r_d = {rx_r_q[DATA_W-2:0], SDout};
        end

        // The final bit is folded in directly so completion needs no extra cycle.
        if (sclk_rise && last_slot && !lr)
            hold_l_d = {rx_l_q[DATA_W-2:0], SDout};

        // First two frames after RSTn rises let the CODEC settle; no strobe.
        if (sclk_rise && last_slot && lr && frm_q >= 2'd2) begin
            vld_d    = 1'b1;
            lft_in_d = hold_l_q;
            rht_in_d = {rx_r_q[DATA_W-2:0], SDout};
        end

        if (vld_q) begin
            txb_l_d = tx_src_l;
            txb_r_d = tx_src_r;
        end

        // One shifter serves both halves: left loads at end of frame, right at
        // mid-frame; a load wins over a shift landing on the same edge.
        if (wrap)
            tx_sh_d = txb_l_q;
        else if (rload)
            tx_sh_d = txb_r_q;
        else if (sclk_fall && tx_slot)
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};

        if (sclk_fall)
            sdin_d = tx_slot ? tx_sh_q[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            rstn_q   <= 1'b0;
            frm_q    <= 2'd0;
            rx_l_q   <= '0;
            rx_r_q   <= '0;
            hold_l_q <= '0;
            lft_in_q <= '0;
            rht_in_q <= '0;
            vld_q    <= 1'b0;
            txb_l_q  <= '0;
            txb_r_q  <= '0;
            tx_sh_q  <= '0;
            sdin_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rstn_q   <= rstn_d;
            frm_q    <= frm_d;
            rx_l_q   <= rx_l_d;
            rx_r_q   <= rx_r_d;
            hold_l_q <= hold_l_d;
            lft_in_q <= lft_in_d;
            rht_in_q <= rht_in_d;
            vld_q    <= vld_d;
            txb_l_q  <= txb_l_d;
            txb_r_q  <= txb_r_d;
            tx_sh_q  <= tx_sh_d;
            sdin_q   <= sdin_d;
        end
    end

    assign MCLK   = cnt_q[1];
    assign SCLK   = cnt_q[3];
    assign LRCLK  = cnt_q[CNT_W-1];
    assign RSTn   = rstn_q;
    assign SDin   = sdin_q;
    assign lft_in = lft_in_q;
    assign rht_in = rht_in_q;
    assign vld    = vld_q;
endmodule

// File: tb/tb_codec_serial_intf.sv
// Purpose : self-checking bench for codec_serial_intf with a CS4272-like model.
// Latency : model reacts on the falling clk edge to the CODEC clocks it sees.
// Backpr. : none; bench consumes every vld strobe.
module tb_codec_serial_intf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MCLK, SCLK, LRCLK, RSTn, SDin, vld;
    logic        SDout = 1'b0;
    logic [15:0] lft_out = 16'h8001;
    logic [15:0] rht_out = 16'h7FFE;
    logic [15:0] lft_in, rht_in;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Words the CODEC ADC model sends, and what its DAC reconstructs.
    logic [15:0] adc_l = 16'hA5C3;
    logic [15:0] adc_r = 16'h1234;
    logic [15:0] aout_lft = '0, aout_rht = '0;

    logic [31:0] rx_q[$];
    logic [31:0] tx_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    codec_serial_intf #(.DATA_W(16), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .RSTn(RSTn),
        .SDout(SDout), .SDin(SDin), .lft_out(lft_out), .rht_out(rht_out),
        .lft_in(lft_in), .rht_in(rht_in), .vld(vld)
    );

    always #5 clk = ~clk;

    // Clocks elapsed since reset release; equals the DUT divider count.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // CODEC model and scoreboard, evaluated mid-cycle.
    int          slot;
    logic        prev_lr, prev_sc, prev_vld;
    logic [15:0] cur_l, cur_r, acc;
    int          last_vld;
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            slot = 0; prev_lr = 0; prev_sc = 0; prev_vld = 0;
            cur_l = adc_l; cur_r = adc_r; acc = '0;
            aout_lft = '0; aout_rht = '0; SDout = 1'b0;
            last_vld = -1;
            rx_q.delete(); tx_q.delete();
        end else begin
            if (LRCLK !== prev_lr) begin
                slot = 0;
                if (LRCLK) cur_r = adc_r; else cur_l = adc_l;
            end else if (prev_sc && !SCLK) begin
                slot++;
                if (LRCLK && slot == 16) rx_q.push_back({cur_l, cur_r});
            end
            if (slot >= 1 && slot <= 16)
                SDout = LRCLK ? cur_r[16-slot] : cur_l[16-slot];
            else
                SDout = 1'b0;

            // DAC side: sample SDin on SCLK rise.
            if (!prev_sc && SCLK) begin
                if (slot >= 1 && slot <= 16) begin
                    acc = {acc[14:0], SDin};
                    if (slot == 16) begin
                        if (!LRCLK) aout_lft = acc;
                        else begin
                            aout_rht = acc;
                            e = (tx_q.size() != 0) ? tx_q.pop_front() : 32'h0;
                            chk("aout_lft", aout_lft, e[31:16]);
                            chk("aout_rht", aout_rht, e[15:0]);
                        end
                    end
                end else begin
                    chk("sdin_idle_slot", SDin, 1'b0);
                end
            end

            if (vld === 1'b1) begin
                chk("vld_width", prev_vld, 1'b0);
                chk("vld_after_startup", (cyc >= 3072), 1'b1);
                if (last_vld >= 0) begin
                    chk("vld_spacing", cyc - last_vld, 1024);
                end
                last_vld = cyc;
                e = 32'h0;
                chk("rx_expected_present", (rx_q.size() != 0), 1'b1);
                if (rx_q.size() != 0) begin
                    e = rx_q[$];
                    rx_q.delete();
                    chk("lft_in", lft_in, e[31:16]);
                    chk("rht_in", rht_in, e[15:0]);
                end
`ifdef CODEC_LOOPBACK_EN
                tx_q.push_back(e);
`else
                tx_q.push_back({lft_out, rht_out});
`endif
            end
            prev_lr = LRCLK; prev_sc = SCLK; prev_vld = vld;
        end
    end

    task automatic wait_vld();
        bit seen = 0;
        for (int i = 0; i < 4096 && !seen; i++) begin
            @(negedge clk);
            if (vld === 1'b1) seen = 1;
        end
        chk("vld_timeout", seen, 1'b1);
    endtask

    // Divider phases, RSTn timing and vld silence for the first 2100 clk.
    task automatic check_startup();
        for (int i = 0; i < 2100; i++) begin
            logic [9:0] c;
            @(negedge clk);
            c = cyc[9:0];
            chk("clk_phase", {MCLK, SCLK, LRCLK}, {c[1], c[3], c[9]});
            chk("rstn", RSTn, (cyc >= 1024));
            chk("vld_quiet", vld, 1'b0);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mclk", MCLK, 1'b0);
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_lrclk", LRCLK, 1'b0);
        chk("rst_rstn", RSTn, 1'b0);
        chk("rst_sdin", SDin, 1'b0);
        chk("rst_vld", vld, 1'b0);
        chk("rst_lft_in", lft_in, 16'h0);
        chk("rst_rht_in", rht_in, 16'h0);
    endtask

    initial begin
        // Reset and clock generation.
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;
        check_startup();

        // Receive A5C3/1234, transmit 8001/7FFE.
        repeat (4) wait_vld();

        // Second pattern on both directions.
        adc_l = 16'h5A3C; adc_r = 16'hFEDC; rht_out = 16'h0F0F;
        repeat (3) wait_vld();

        // Capture timing: a change one clk after vld waits a frame.
        lft_out = 16'h0001;
        wait_vld();
        @(posedge clk); #1 lft_out = 16'hFFFF;
        repeat (3) wait_vld();

        // Mid-frame reset during the right half.
        for (int i = 0; i < 2048 && !(cyc % 1024 == 699); i++) @(negedge clk);
        chk("midrst_pos", cyc % 1024, 699);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        #1 rst = 1'b0;
        check_startup();
        repeat (3) wait_vld();

`ifdef CODEC_LOOPBACK_EN
        // Loopback: received words come back out; lft_out/rht_out are ignored.
        adc_l = 16'h00FF; adc_r = 16'hFF00;
        for (int i = 0; i < 4; i++) begin
            wait_vld();
            @(posedge clk); #1 lft_out = ~lft_out; rht_out = ~rht_out;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
